// File: rtl/sram_sched_pkg.sv
// rtl/sram_sched_pkg.sv - shared types and constants for the SRAM access scheduler
package sram_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int MAX_STROBE = 4;
  localparam int CNT_W      = $clog2(MAX_STROBE);

endpackage

// File: rtl/sram_access_sched_arb.sv
// rtl/sram_access_sched_arb.sv - combinational round-robin arbiter, one-hot grant
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N_REQ-1:0] grant
);

  logic found;

  // First pass searches pointer..N_REQ-1, second pass wraps to 0..pointer-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i >= int'(pointer))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i < int'(pointer))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_access_sched.sv
// rtl/sram_access_sched.sv - round-robin sequencer of setup/strobe/recover SRAM row accesses
module sram_access_sched
  import sram_sched_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int N_REQ         = 2,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         dec_select,
  output logic                      dec_enable,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int PTR_W = $clog2(N_REQ);

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, owner, win_id;
  logic [CNT_W-1:0]   cnt;
  logic [N_REQ-1:0]   grant, rsp_nxt;
  logic               accept, enable_nxt, we_nxt;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req     (req_valid),
    .pointer (ptr),
    .grant   (grant)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) win_id = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (cnt == '0) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are loaded from the next state so they line up with it.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && rst_n) req_ready = grant;
    accept     = |req_ready;
    enable_nxt = (state_nxt == STROBE);
    we_nxt     = 1'b0;
    if (state_nxt == SETUP)       we_nxt = req_we[win_id];
    else if (state_nxt == STROBE) we_nxt = mem_we;
    rsp_nxt = '0;
    if (state_nxt == RECOVER) rsp_nxt[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      dec_select <= '0;
      dec_enable <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      dec_enable <= enable_nxt;
      mem_we     <= we_nxt;
      rsp_valid  <= rsp_nxt;
      if (accept) begin
        dec_select <= req_addr[win_id*ADDR_W +: ADDR_W];
        mem_wdata  <= req_wdata[win_id*DATA_W +: DATA_W];
        owner      <= win_id;
        ptr        <= (int'(win_id) == N_REQ-1) ? '0 : win_id + 1'b1;
      end
      if (state == SETUP)                   cnt <= CNT_W'(STROBE_CYCLES-1);
      else if (state == STROBE && cnt != '0) cnt <= cnt - 1'b1;
      if (state == STROBE && cnt == '0 && !mem_we) rsp_rdata <= mem_rdata;
    end
  end

endmodule
